fwd_pipe_mux: RTL and testbench
===============================

# fwd_pipe_mux

Parametrised forwarding multiplexer for the pipelined datapath. It tracks the register writes still in flight in the last NSTAGE pipeline stages (E, M, W by default). For two register-read ports it selects the youngest in-flight value or falls back to the register-file value. It raises a hazard flag when the matching writer's data is not yet produced, for example a load still in E. It sits between the register file read outputs and the E-stage operand inputs and replaces the fixed 3:1 operand muxes.

## Interface

Parameters:
- WIDTH, 32, data width
- AW, 5, register address width
- NSTAGE, 3, number of tracked writer stages (≥2); stage 0 = E, stage NSTAGE-1 = W
- SW, $clog2(NSTAGE+1), width of select outputs (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  hold all tracked stages (multicycle unit busy)
- flush  in  1  invalidate the entry currently in stage 0
- wr_en  in  1  instruction entering stage 0 writes a register
- wr_addr  in  AW  its destination register
- wr_rdy  in  1  its result is already known at entry (ALU/link), 0 for loads
- wr_data  in  WIDTH  its result (ignored when wr_rdy=0)
- fill_en  in  1  late result for the entry in stage 0 is available
- fill_data  in  WIDTH  that late result
- rd_en_a, rd_en_b  in  1  read port uses the operand
- rd_addr_a, rd_addr_b  in  AW  source register
- rf_data_a, rf_data_b  in  WIDTH  register-file value for that source
- out_a, out_b  out  WIDTH  selected operand
- sel_a, sel_b  out  SW  0 = register file, i+1 = stage i
- hazard  out  1  stall request to decode

## Operation

- State per stage i: v[i], addr[i], data[i], rdy[i].
- Reset: all v, addr, data, rdy = 0. Outputs then are out_x = rf_data_x (0 when rd_addr_x = 0), sel_x = 0, hazard = 0.
- Advance, every edge with freeze=0:
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= {wr_en & (wr_addr≠0), wr_addr, wr_data, wr_rdy}.
  - The W entry is dropped, because the register file holds it from the next cycle.
- Fill:
  - Applies only if fill_en and v[0] and !rdy[0]; otherwise ignored.
  - With freeze=0, the entry moving into stage 1 carries data = fill_data, rdy = 1.
  - With freeze=1, stage 0 is updated in place.
- Flush:
  - freeze=0: flush acts on the outgoing stage-0 entry, so stage 1 receives v=0. New entry acceptance is unaffected.
  - freeze=1: v[0] <= 0 in place.
- Freeze: entries hold except for fill/flush on stage 0. wr_* is ignored, and the caller must hold the instruction.
- Read port x (combinational from state):
  - Match: v[i] & addr[i]==rd_addr_x & rd_addr_x≠0. The lowest i wins (youngest).
  - rd_addr_x = 0: out_x = 0, sel_x = 0.
  - No match: out_x = rf_data_x, sel_x = 0.
  - Match at i with rdy[i]=1: out_x = data[i], sel_x = i+1.
  - Match at i with rdy[i]=0: out_x = rf_data_x, sel_x = i+1, port hazard.
  - Older matches never override a younger one, even when the younger entry is not ready.
- hazard = (rd_en_a & hazard_a) | (rd_en_b & hazard_b). sel/out are driven regardless of rd_en.

## Timing

- Entry presented with wr_en in cycle k is visible at stage 0 in cycle k+1, at stage NSTAGE-1 in cycle k+NSTAGE, and gone in cycle k+NSTAGE+1 (with no freeze).
- Fill in cycle k is visible in cycle k+1.
- out/sel/hazard settle combinationally within the cycle; no output register.
- hazard does not feed back internally. The caller converts it into wr_en=0 (bubble) the next cycle.
- Reset is asynchronous: assertion mid-operation clears all stages immediately, and hazard drops in the same cycle.

## Test plan

- Reset, then rd_addr_a=8, rf_data_a=0x11 -> out_a=0x11, sel_a=0, hazard=0. Assert rst_n=0 with 3 valid entries -> all sel=0 immediately.
- wr_en, addr 8, rdy=1, data 0xA5 at cycle 0; read $8 cycles 1..3 -> sel_a=1,2,3, out_a=0xA5. Cycle 4 -> sel_a=0, out_a=rf_data_a.
- Two writers to $9 (0x1 then 0x2) back-to-back; read $9 in the cycle after the second enters -> out_b=0x2, sel_b=1.
- Load to $4 (rdy=0), rd_en_a with rd_addr_a=4 next cycle -> hazard=1. fill_en, fill_data=0x77 that cycle -> next cycle sel_a=2, out_a=0x77, hazard=0.
- freeze=1 for 2 cycles holding an entry at stage 1 -> sel stays 2. flush with freeze on stage 0 -> its match disappears next cycle.
- wr_addr=0 with wr_en=1, data 0xFF; read $0 -> out=0, sel=0, hazard=0. Load to $5 with rd_en_b=0 -> hazard=0.

Source files
------------

// File: rtl/fwd_pipe_mux.sv
// Operand forwarding mux: tracks in-flight register writes over NSTAGE stages
// and picks the youngest matching value per read port, flagging unready producers.
module fwd_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NSTAGE = 3,
    localparam int SW    = $clog2(NSTAGE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fill_en,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [WIDTH-1:0] rf_data_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [WIDTH-1:0] rf_data_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [SW-1:0]    sel_a,
    output logic [SW-1:0]    sel_b,
    output logic             hazard
);

    logic [NSTAGE-1:0] v_q, v_d;
    logic [NSTAGE-1:0] rdy_q, rdy_d;
    logic [AW-1:0]     addr_q [NSTAGE];
    logic [AW-1:0]     addr_d [NSTAGE];
    logic [WIDTH-1:0]  data_q [NSTAGE];
    logic [WIDTH-1:0]  data_d [NSTAGE];

    logic             fill_ok;
    logic             s0_v;
    logic             s0_rdy;
    logic [WIDTH-1:0] s0_data;

    // Stage 0 as it looks after applying this cycle's fill/flush; either shifts or stays.
    assign fill_ok = fill_en & v_q[0] & ~rdy_q[0];
    assign s0_v    = v_q[0] & ~flush;
    assign s0_rdy  = rdy_q[0] | fill_ok;
    assign s0_data = fill_ok ? fill_data : data_q[0];

    always_comb begin
        v_d    = v_q;
        rdy_d  = rdy_q;
        addr_d = addr_q;
        data_d = data_q;
        if (!freeze) begin
            for (int unsigned i = 2; i < NSTAGE; i++) begin
                v_d[i]    = v_q[i-1];
                rdy_d[i]  = rdy_q[i-1];
                addr_d[i] = addr_q[i-1];
                data_d[i] = data_q[i-1];
            end
            v_d[1]    = s0_v;
            rdy_d[1]  = s0_rdy;
            addr_d[1] = addr_q[0];
            data_d[1] = s0_data;
            v_d[0]    = wr_en & (wr_addr != '0);
            rdy_d[0]  = wr_rdy;
            addr_d[0] = wr_addr;
            data_d[0] = wr_data;
        end else begin
            v_d[0]    = s0_v;
            rdy_d[0]  = s0_rdy;
            data_d[0] = s0_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            rdy_q <= '0;
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            rdy_q  <= rdy_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rf_data [2];
    logic [WIDTH-1:0] out_v   [2];
    logic [SW-1:0]    sel_v   [2];
    logic [1:0]       hz;

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rf_data[0] = rf_data_a;
    assign rf_data[1] = rf_data_b;

    // Ascending scan with a found flag: the youngest match blocks all older ones.
    always_comb begin
        logic found;
        found = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            out_v[p] = rf_data[p];
            sel_v[p] = '0;
            hz[p]    = 1'b0;
            found    = 1'b0;
            if (rd_addr[p] == '0) begin
                out_v[p] = '0;
            end else begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    if (!found && v_q[i] && (addr_q[i] == rd_addr[p])) begin
                        found    = 1'b1;
                        sel_v[p] = SW'(i + 1);
                        if (rdy_q[i]) out_v[p] = data_q[i];
                        else          hz[p]    = 1'b1;
                    end
                end
            end
        end
    end

    assign out_a  = out_v[0];
    assign out_b  = out_v[1];
    assign sel_a  = sel_v[0];
    assign sel_b  = sel_v[1];
    assign hazard = (rd_en_a & hz[0]) | (rd_en_b & hz[1]);

endmodule

// File: tb/tb_fwd_pipe_mux.sv
// Bench for fwd_pipe_mux: per-cycle vector table through a scoreboard queue,
// then a hand sequence for asynchronous reset with live entries.
module tb_fwd_pipe_mux;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int SW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             freeze, flush, wr_en, wr_rdy, fill_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data, fill_data;
    logic             rd_en_a, rd_en_b;
    logic [AW-1:0]    rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0] rf_data_a, rf_data_b;
    logic [WIDTH-1:0] out_a, out_b;
    logic [SW-1:0]    sel_a, sel_b;
    logic             hazard;

    int checks   = 0;
    int failures = 0;

    fwd_pipe_mux #(.WIDTH(WIDTH), .AW(AW), .NSTAGE(3)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .fill_en(fill_en), .fill_data(fill_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rf_data_a(rf_data_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rf_data_b(rf_data_b),
        .out_a(out_a), .out_b(out_b), .sel_a(sel_a), .sel_b(sel_b), .hazard(hazard)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             frz, fl, we;
        logic [AW-1:0]    wa;
        logic             wrdy;
        logic [WIDTH-1:0] wd;
        logic             fe;
        logic [WIDTH-1:0] fd;
        logic             rea;
        logic [AW-1:0]    raa;
        logic [WIDTH-1:0] rfa;
        logic             reb;
        logic [AW-1:0]    rab;
        logic [WIDTH-1:0] rfb;
        logic [WIDTH-1:0] eoa;
        logic [SW-1:0]    esa;
        logic [WIDTH-1:0] eob;
        logic [SW-1:0]    esb;
        logic             ehz;
    } vec_t;

    function automatic vec_t V(
        input logic frz, input logic fl, input logic we, input logic [AW-1:0] wa,
        input logic wrdy, input logic [WIDTH-1:0] wd, input logic fe, input logic [WIDTH-1:0] fd,
        input logic rea, input logic [AW-1:0] raa, input logic [WIDTH-1:0] rfa,
        input logic reb, input logic [AW-1:0] rab, input logic [WIDTH-1:0] rfb,
        input logic [WIDTH-1:0] eoa, input logic [SW-1:0] esa,
        input logic [WIDTH-1:0] eob, input logic [SW-1:0] esb, input logic ehz);
        vec_t r;
        r.frz = frz; r.fl = fl; r.we = we; r.wa = wa; r.wrdy = wrdy; r.wd = wd;
        r.fe = fe; r.fd = fd; r.rea = rea; r.raa = raa; r.rfa = rfa;
        r.reb = reb; r.rab = rab; r.rfb = rfb;
        r.eoa = eoa; r.esa = esa; r.eob = eob; r.esb = esb; r.ehz = ehz;
        return r;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        freeze = t.frz; flush = t.fl; wr_en = t.we; wr_addr = t.wa; wr_rdy = t.wrdy;
        wr_data = t.wd; fill_en = t.fe; fill_data = t.fd;
        rd_en_a = t.rea; rd_addr_a = t.raa; rf_data_a = t.rfa;
        rd_en_b = t.reb; rd_addr_b = t.rab; rf_data_b = t.rfb;
    endtask

    vec_t sb[$];
    vec_t tbl[15];
    vec_t idle;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // frz fl we wa wrdy wd fe fd | rea raa rfa | reb rab rfb | eoa esa eob esb ehz
        tbl[0]  = V(0,0,1,8, 1,'hA5,  0,0,    1,8,'h11, 1,0, 'h22, 'h11,0,'h0, 0,0);
        tbl[1]  = V(0,0,1,9, 1,'h1,   0,0,    1,8,'h11, 1,9, 'h22, 'hA5,1,'h22,0,0);
        tbl[2]  = V(0,0,1,9, 1,'h2,   0,0,    1,8,'h11, 1,9, 'h22, 'hA5,2,'h1, 1,0);
        tbl[3]  = V(0,0,0,0, 0,'h0,   0,0,    1,8,'h11, 1,9, 'h22, 'hA5,3,'h2, 1,0);
        tbl[4]  = V(0,0,1,4, 0,'hDEAD,0,0,    1,8,'h33, 1,9, 'h22, 'h33,0,'h2, 2,0);
        tbl[5]  = V(0,0,0,0, 0,'h0,   1,'h77, 1,4,'h44, 1,9, 'h22, 'h44,1,'h2, 3,1);
        tbl[6]  = V(1,0,1,10,1,'hBAD, 0,0,    1,4,'h44, 1,9, 'h55, 'h77,2,'h55,0,0);
        tbl[7]  = V(1,0,0,0, 0,'h0,   0,0,    1,4,'h44, 1,10,'h66, 'h77,2,'h66,0,0);
        tbl[8]  = V(0,0,1,5, 0,'h0,   0,0,    1,4,'h44, 0,5, 'h88, 'h77,2,'h88,0,0);
        tbl[9]  = V(1,1,0,0, 0,'h0,   0,0,    1,4,'h44, 0,5, 'h99, 'h77,3,'h99,1,0);
        tbl[10] = V(0,0,1,0, 1,'hFF,  0,0,    1,4,'h44, 1,5, 'h99, 'h77,3,'h99,0,0);
        tbl[11] = V(0,0,1,6, 1,'h60,  0,0,    1,0,'h12, 1,4, 'h44, 'h0, 0,'h44,0,0);
        tbl[12] = V(0,1,1,7, 1,'h70,  0,0,    1,6,'h16, 1,7, 'h07, 'h60,1,'h07,0,0);
        tbl[13] = V(0,0,1,7, 0,'h0,   0,0,    1,6,'h16, 1,7, 'h17, 'h16,0,'h70,1,0);
        tbl[14] = V(0,0,0,0, 0,'h0,   0,0,    1,0,'h12, 1,7, 'h17, 'h0, 0,'h17,1,1);
        idle    = V(0,0,0,0, 0,'h0,   0,0,    0,0,'h0,  0,0, 'h0,  'h0, 0,'h0, 0,0);

        rst_n = 1'b0;
        drive(idle);
        rd_addr_a = 5'd8; rf_data_a = 32'h11;
        #3;
        chk("reset_out_a", out_a, 32'h11);
        chk("reset_sel_a", 32'(sel_a), 32'd0);
        chk("reset_hazard", 32'(hazard), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("v%0d_out_a", i), out_a, e.eoa);
                chk($sformatf("v%0d_sel_a", i), 32'(sel_a), 32'(e.esa));
                chk($sformatf("v%0d_out_b", i), out_b, e.eob);
                chk($sformatf("v%0d_sel_b", i), 32'(sel_b), 32'(e.esb));
                chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(e.ehz));
            end
        end

        // Three live entries ($8, $8, load $3), then asynchronous reset mid-cycle.
        @(posedge clk); #1;
        drive(idle);
        wr_en = 1'b1; wr_addr = 5'd8; wr_rdy = 1'b1; wr_data = 32'hAB;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_addr = 5'd3; wr_rdy = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd8; rf_data_a = 32'h11;
        rd_en_b = 1'b1; rd_addr_b = 5'd3; rf_data_b = 32'h33;
        #2;
        chk("live_sel_a", 32'(sel_a), 32'd2);
        chk("live_out_a", out_a, 32'hAB);
        chk("live_sel_b", 32'(sel_b), 32'd1);
        chk("live_hazard", 32'(hazard), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_sel_a", 32'(sel_a), 32'd0);
        chk("arst_out_a", out_a, 32'h11);
        chk("arst_sel_b", 32'(sel_b), 32'd0);
        chk("arst_out_b", out_b, 32'h33);
        chk("arst_hazard", 32'(hazard), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
